// File: rtl/dac_writer_defs.sv
// Shared constants for the retroaction DAC writer: default command prefix,
// FSM state encodings and counter sizing helper.
package dac_writer_defs;

    localparam logic [7:0]  DEFAULT_COMMAND = 8'h30;
    localparam int unsigned OVERRUN_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Bits needed for a counter running 0 .. max_val-1 (never less than one).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/dac_frame_shifter.sv
// Serializes one FRAME_BITS word MSB first: low phase then high phase of CLK_DIV
// cycles per bit; done_c marks the last cycle of the final high phase.
module dac_frame_shifter
    import dac_writer_defs::*;
#(
    parameter int unsigned FRAME_BITS = 24,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  sclk,
    output logic                  sdi,
    output logic                  done_c
);

    localparam int unsigned     HW        = cnt_width(CLK_DIV);
    localparam int unsigned     BW        = cnt_width(FRAME_BITS);
    localparam logic [HW-1:0]   HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST  = BW'(FRAME_BITS - 1);

    // Holds the bits still to be sent after the one currently on sdi.
    logic [FRAME_BITS-1:0] shreg;
    logic [HW-1:0]         half_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  high_phase;
    logic                  active;
    logic                  phase_end_c;

    assign phase_end_c = (half_cnt == HALF_LAST);
    assign done_c      = active && high_phase && phase_end_c && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            high_phase <= 1'b0;
            active     <= 1'b0;
            sclk       <= 1'b0;
            sdi        <= 1'b0;
        end else if (start) begin
            shreg      <= {frame[FRAME_BITS-2:0], 1'b0};
            sdi        <= frame[FRAME_BITS-1];
            sclk       <= 1'b0;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            high_phase <= 1'b0;
            active     <= 1'b1;
        end else if (active) begin
            if (phase_end_c) begin
                half_cnt <= '0;
                if (!high_phase) begin
                    high_phase <= 1'b1;
                    sclk       <= 1'b1;
                end else begin
                    high_phase <= 1'b0;
                    sclk       <= 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        active <= 1'b0;
                        sdi    <= 1'b0;
                    end else begin
                        // Next bit goes out at the start of the following low phase.
                        bit_cnt <= bit_cnt + BW'(1);
                        sdi     <= shreg[FRAME_BITS-1];
                        shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end else begin
                half_cnt <= half_cnt + HW'(1);
            end
        end
    end

endmodule

// File: rtl/retroaction_dac_writer.sv
// Converts controller correction samples to DAC codes and writes each as one
// SPI-style frame; a single pending slot absorbs samples arriving mid-frame.
module retroaction_dac_writer
    import dac_writer_defs::*;
#(
    parameter int unsigned                          DATA_WIDTH     = 16,
    parameter int unsigned                          FRAME_BITS     = 24,
    parameter logic [FRAME_BITS-DATA_WIDTH-1:0]     COMMAND        = DEFAULT_COMMAND,
    parameter int unsigned                          CLK_DIV        = 2,
    parameter int unsigned                          CS_IDLE_CYCLES = 2,
    parameter bit                                   OFFSET_BINARY  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  data_valid,
    output logic                  dac_sclk,
    output logic                  dac_cs_n,
    output logic                  dac_sdi,
    output logic                  busy,
    output logic [OVERRUN_W-1:0]  overrun_count,
    output logic [DATA_WIDTH-1:0] last_code
);

    localparam int unsigned   CW        = cnt_width((CLK_DIV > CS_IDLE_CYCLES) ? CLK_DIV : CS_IDLE_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(CS_IDLE_CYCLES - 1);

    state_t                  state;
    logic                    pend_valid;
    logic [DATA_WIDTH-1:0]   pend_data;
    logic [CW-1:0]           cnt;

    logic [DATA_WIDTH-1:0]   sel_data_c;
    logic [DATA_WIDTH-1:0]   code_c;
    logic [FRAME_BITS-1:0]   frame_c;
    logic                    start_c;
    logic                    done_c;

    // A fresh sample beats the pending one when both are available in IDLE.
    always_comb begin
        sel_data_c = data_valid ? data : pend_data;
        code_c     = sel_data_c;
        if (OFFSET_BINARY) begin
            code_c[DATA_WIDTH-1] = ~sel_data_c[DATA_WIDTH-1];
        end
        frame_c = {COMMAND, code_c};
        start_c = (state == ST_IDLE) && (data_valid || pend_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            pend_valid    <= 1'b0;
            pend_data     <= '0;
            cnt           <= '0;
            dac_cs_n      <= 1'b1;
            busy          <= 1'b0;
            overrun_count <= '0;
            last_code     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        last_code  <= code_c;
                        busy       <= 1'b1;
                        dac_cs_n   <= 1'b0;
                        pend_valid <= 1'b0;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (done_c) begin
                        cnt   <= '0;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= '0;
                        dac_cs_n <= 1'b1;
                        state    <= ST_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Mid-frame samples park in the pending slot; newest overwrites.
            if (data_valid && (state != ST_IDLE)) begin
                pend_data  <= data;
                pend_valid <= 1'b1;
                if (pend_valid && (overrun_count != '1)) begin
                    overrun_count <= overrun_count + OVERRUN_W'(1);
                end
            end
        end
    end

    dac_frame_shifter #(
        .FRAME_BITS (FRAME_BITS),
        .CLK_DIV    (CLK_DIV)
    ) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .start  (start_c),
        .frame  (frame_c),
        .sclk   (dac_sclk),
        .sdi    (dac_sdi),
        .done_c (done_c)
    );

endmodule

// File: tb/tb_retroaction_dac_writer.sv
// Self-checking bench for retroaction_dac_writer: a default instance and a
// fast, pass-through instance (CLK_DIV=1, CS_IDLE_CYCLES=1, OFFSET_BINARY=0).
module tb_retroaction_dac_writer;

    localparam int FB = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] data_a, data_b;
    logic        valid_a, valid_b;
    logic        sclk_a, cs_a, sdi_a, busy_a;
    logic        sclk_b, cs_b, sdi_b, busy_b;
    logic [15:0] ov_a, ov_b, lc_a, lc_b;

    retroaction_dac_writer dut_a (
        .clk(clk), .reset(reset), .data(data_a), .data_valid(valid_a),
        .dac_sclk(sclk_a), .dac_cs_n(cs_a), .dac_sdi(sdi_a), .busy(busy_a),
        .overrun_count(ov_a), .last_code(lc_a)
    );

    retroaction_dac_writer #(
        .CLK_DIV(1), .CS_IDLE_CYCLES(1), .OFFSET_BINARY(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .data(data_b), .data_valid(valid_b),
        .dac_sclk(sclk_b), .dac_cs_n(cs_b), .dac_sdi(sdi_b), .busy(busy_b),
        .overrun_count(ov_b), .last_code(lc_b)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [15:0] ob_code(input logic [15:0] d);
        return d ^ 16'h8000;
    endfunction

    // One frame from IDLE on the selected instance; timing from the frame formulas.
    task automatic frame_test(input int sel, input logic [15:0] d, input logic [15:0] exp_code, input string tag);
        int cd, csi, hi_end, idle_at, nrise, cs_first, cs_last, cs_cnt, busy_drop;
        logic [FB-1:0] bits;
        logic prev_sclk, rise_ok, sc, cs, sd, bz;
        logic [15:0] lc;
        cd = (sel == 0) ? 2 : 1;
        csi = (sel == 0) ? 2 : 1;
        hi_end = 2*cd*FB + cd;
        idle_at = hi_end + csi + 1;
        nrise = 0; cs_first = -1; cs_last = -1; cs_cnt = 0; busy_drop = -1;
        bits = '0; prev_sclk = 1'b0; rise_ok = 1'b1;
        do_reset();
        if (sel == 0) begin data_a = d; valid_a = 1'b1; end
        else          begin data_b = d; valid_b = 1'b1; end
        for (int c = 1; c <= idle_at + 3; c++) begin
            step();
            valid_a = 1'b0;
            valid_b = 1'b0;
            sc = (sel == 0) ? sclk_a : sclk_b;
            cs = (sel == 0) ? cs_a   : cs_b;
            sd = (sel == 0) ? sdi_a  : sdi_b;
            bz = (sel == 0) ? busy_a : busy_b;
            if (sc && !prev_sclk) begin
                if (nrise < FB) bits[FB-1-nrise] = sd;
                if (c != 1 + cd + 2*cd*nrise) rise_ok = 1'b0;
                nrise++;
            end
            prev_sclk = sc;
            if (!cs) begin
                if (cs_first < 0) cs_first = c;
                cs_last = c;
                cs_cnt++;
            end
            if (!bz && busy_drop < 0) busy_drop = c;
        end
        lc = (sel == 0) ? lc_a : lc_b;
        check({tag, " frame bits"}, 64'(bits), 64'({8'h30, exp_code}));
        check({tag, " rise count"}, 64'(nrise), 64'(FB));
        check({tag, " rise times"}, 64'(rise_ok), 64'(1));
        check({tag, " cs first low"}, 64'(cs_first), 64'(1));
        check({tag, " cs last low"}, 64'(cs_last), 64'(hi_end));
        check({tag, " cs low length"}, 64'(cs_cnt), 64'(hi_end));
        check({tag, " busy drop"}, 64'(busy_drop), 64'(idle_at));
        check({tag, " last_code"}, 64'(lc), 64'(exp_code));
    endtask

    typedef struct {
        int          sel;
        logic [15:0] d;
        logic [15:0] code;
    } vec_t;

    vec_t vecs[6];

    // Random-phase reference model state
    int          m_idle_at;
    logic        m_pend_v;
    logic [15:0] m_pend_d;
    int          m_ov;
    logic [15:0] m_last;
    logic [23:0] exp_q[$];

    task automatic model_step(input int c, input logic v, input logic [15:0] d);
        if (c >= m_idle_at) begin
            if (v || m_pend_v) begin
                m_last = ob_code(v ? d : m_pend_d);
                exp_q.push_back({8'h30, m_last});
                m_pend_v = 1'b0;
                m_idle_at = c + 101;
            end
        end else if (v) begin
            if (m_pend_v && m_ov < 65535) m_ov++;
            m_pend_v = 1'b1;
            m_pend_d = d;
        end
    endtask

    initial begin
        vecs[0] = '{0, 16'h0000, 16'h8000};
        vecs[1] = '{0, 16'h7FFF, 16'hFFFF};
        vecs[2] = '{0, 16'h8000, 16'h0000};
        vecs[3] = '{0, 16'h1234, 16'h9234};
        vecs[4] = '{1, 16'h8000, 16'h8000};
        vecs[5] = '{1, 16'h1234, 16'h1234};

        // Reset state
        do_reset();
        check("reset sclk", 64'(sclk_a), 64'(0));
        check("reset cs_n", 64'(cs_a), 64'(1));
        check("reset sdi", 64'(sdi_a), 64'(0));
        check("reset busy", 64'(busy_a), 64'(0));
        check("reset overrun", 64'(ov_a), 64'(0));
        check("reset last_code", 64'(lc_a), 64'(0));

        // Single frames, both code formats and both timings
        foreach (vecs[i]) begin
            frame_test(vecs[i].sel, vecs[i].d, vecs[i].code, $sformatf("vec%0d", i));
        end

        // A at 0, B at 10, C at 20: C overwrites B and follows A back-to-back
        begin
            logic [47:0] bits;
            int nrise, c_seen;
            logic prev_sclk, saw_b;
            do_reset();
            bits = '0; nrise = 0; c_seen = -1; prev_sclk = 1'b0; saw_b = 1'b0;
            data_a = 16'h1111; valid_a = 1'b1;
            for (int c = 1; c <= 210; c++) begin
                step();
                valid_a = 1'b0;
                if (sclk_a && !prev_sclk) begin
                    if (nrise < 48) bits[47-nrise] = sdi_a;
                    nrise++;
                end
                prev_sclk = sclk_a;
                if (lc_a == 16'hA222) saw_b = 1'b1;
                if (lc_a == 16'hB333 && c_seen < 0) c_seen = c;
                if (c == 101) check("abc idle busy", 64'(busy_a), 64'(0));
                if (c == 10) begin data_a = 16'h2222; valid_a = 1'b1; end
                if (c == 20) begin data_a = 16'h3333; valid_a = 1'b1; end
            end
            check("abc bits", 64'(bits), 64'({8'h30, 16'h9111, 8'h30, 16'hB333}));
            check("abc rise count", 64'(nrise), 64'(48));
            check("abc C visible cycle", 64'(c_seen), 64'(102));
            check("abc overrun", 64'(ov_a), 64'(1));
            check("abc B never sent", 64'(saw_b), 64'(0));
        end

        // Reset mid-frame aborts everything, including pending
        begin
            int rises, cs_low, busy_hi;
            logic prev_sclk;
            do_reset();
            rises = 0; cs_low = 0; busy_hi = 0; prev_sclk = 1'b0;
            data_a = 16'h4444; valid_a = 1'b1;
            for (int c = 1; c <= 180; c++) begin
                step();
                valid_a = 1'b0;
                if (c == 51) begin
                    reset = 1'b0;
                    check("abort cs_n", 64'(cs_a), 64'(1));
                    check("abort sclk", 64'(sclk_a), 64'(0));
                    check("abort sdi", 64'(sdi_a), 64'(0));
                    check("abort busy", 64'(busy_a), 64'(0));
                    check("abort overrun", 64'(ov_a), 64'(0));
                    check("abort last_code", 64'(lc_a), 64'(0));
                end
                if (c > 51) begin
                    if (sclk_a && !prev_sclk) rises++;
                    if (!cs_a) cs_low++;
                    if (busy_a) busy_hi++;
                end
                prev_sclk = sclk_a;
                if (c == 49) check("pre-abort overrun", 64'(ov_a), 64'(1));
                if (c == 10) begin data_a = 16'h5555; valid_a = 1'b1; end
                if (c == 20) begin data_a = 16'h6666; valid_a = 1'b1; end
                if (c == 50) reset = 1'b1;
            end
            check("post-abort rises", 64'(rises), 64'(0));
            check("post-abort cs low", 64'(cs_low), 64'(0));
            check("post-abort busy", 64'(busy_hi), 64'(0));
        end

        // Fast instance: pending sample latched in the IDLE cycle 51
        begin
            do_reset();
            data_b = 16'hABCD; valid_b = 1'b1;
            for (int c = 1; c <= 53; c++) begin
                step();
                valid_b = 1'b0;
                if (c == 51) begin
                    check("fast idle cs_n", 64'(cs_b), 64'(1));
                    check("fast idle busy", 64'(busy_b), 64'(0));
                    check("fast first code", 64'(lc_b), 64'(16'hABCD));
                end
                if (c == 52) begin
                    check("fast second cs_n", 64'(cs_b), 64'(0));
                    check("fast second busy", 64'(busy_b), 64'(1));
                    check("fast second code", 64'(lc_b), 64'(16'h8000));
                    check("fast overrun", 64'(ov_b), 64'(0));
                end
                if (c == 5) begin data_b = 16'h8000; valid_b = 1'b1; end
            end
        end

        // Randomized traffic against the abstract frame model
        begin
            logic [23:0] sr, exp_f;
            int nb, bad_busy, bad_last, bad_ov, frames;
            logic prev_sclk, prev_cs, v;
            logic [15:0] d;
            do_reset();
            m_idle_at = 0; m_pend_v = 1'b0; m_pend_d = '0; m_ov = 0; m_last = '0;
            exp_q.delete();
            sr = '0; nb = 0; bad_busy = 0; bad_last = 0; bad_ov = 0; frames = 0;
            prev_sclk = 1'b0; prev_cs = 1'b1;
            for (int c = 0; c < 3300; c++) begin
                if (c > 0) begin
                    step();
                    if (busy_a !== (c < m_idle_at)) bad_busy++;
                    if (lc_a !== m_last) bad_last++;
                    if (ov_a !== 16'(m_ov)) bad_ov++;
                    if (sclk_a && !prev_sclk && !cs_a) begin
                        sr = {sr[22:0], sdi_a};
                        nb++;
                    end
                    if (cs_a && !prev_cs) begin
                        exp_f = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
                        check($sformatf("rand frame %0d", frames), 64'({nb[7:0], sr}), 64'({8'd24, exp_f}));
                        frames++;
                        nb = 0;
                    end
                    prev_sclk = sclk_a;
                    prev_cs = cs_a;
                end
                v = (c < 3000) && ($urandom_range(0, 29) == 0);
                d = 16'($urandom);
                valid_a = v;
                data_a = d;
                model_step(c, v, d);
            end
            valid_a = 1'b0;
            check("rand busy mismatches", 64'(bad_busy), 64'(0));
            check("rand last_code mismatches", 64'(bad_last), 64'(0));
            check("rand overrun mismatches", 64'(bad_ov), 64'(0));
            check("rand frames left unsent", 64'(exp_q.size()), 64'(0));
            check("rand enough frames", 64'(frames > 10), 64'(1));
        end

        // Continuous valid: 99 overwrites per frame until saturation
        begin
            do_reset();
            valid_a = 1'b1;
            data_a = 16'($urandom);
            for (int c = 1; c <= 68000; c++) begin
                step();
                data_a = 16'($urandom);
                if (c == 10100) check("overrun after 100 frames", 64'(ov_a), 64'(9900));
            end
            check("overrun saturated", 64'(ov_a), 64'(16'hFFFF));
            step();
            check("overrun holds", 64'(ov_a), 64'(16'hFFFF));
            valid_a = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
